// File: rtl/mem_bus_pkg.sv
// Purpose: shared types and constants for the nibble-serial external memory bus.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_bus_pkg;

    // Bus transaction sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_RDATA,
        ST_WDATA,
        ST_DONE
    } state_t;

    // Which requester owns (or last owned) the bus.
    typedef enum logic {
        ICACHE = 1'b0,
        DATA   = 1'b1
    } owner_t;

    localparam logic [3:0] CMD_READ  = 4'h1;
    localparam logic [3:0] CMD_WRITE = 4'h2;

    // Number of address nibbles needed to carry a pa-bit physical address.
    function automatic int anib(input int pa);
        return (pa + 3) / 4;
    endfunction

endpackage

// File: rtl/mem_nibble_arb.sv
// Purpose: arbitrates the 4-bit external memory bus between icache line fills and data loads/stores.
// Latency: grant to DONE is 1+ANIB+DUMMY+N cycles for reads, 1+ANIB+N for writes; fill nibbles reach the icache one cycle after sampling.
// Backpressure: requesters hold their request until completion; requests are sampled only in IDLE, one transaction at a time.
module mem_nibble_arb
    import mem_bus_pkg::*;
#(
    parameter int PA          = 22,
    parameter int RV          = 16,
    parameter int LINE_LENGTH = 4,
    parameter int DUMMY       = 2
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                i_pull,
    input  logic [PA-$clog2(LINE_LENGTH)-1:0]   i_tag,
    input  logic                                i_fault,
    output logic [3:0]                          i_dread,
    output logic                                i_wstrobe,
    input  logic                                d_req,
    input  logic                                d_write,
    input  logic                                d_size,
    input  logic [PA-1:0]                       d_addr,
    input  logic [RV-1:0]                       d_wdata,
    output logic                                d_ack,
    output logic [RV-1:0]                       d_rdata,
    output logic                                m_csn,
    output logic                                m_oe,
    output logic [3:0]                          m_dout,
    input  logic [3:0]                          m_din
);

    localparam int OFFW     = $clog2(LINE_LENGTH);
    localparam int ANIB     = anib(PA);
    localparam int AW       = ANIB * 4;
    localparam int FILL_NIB = LINE_LENGTH * 2;
    localparam int CNT_MAX1 = (ANIB > DUMMY) ? ANIB : DUMMY;
    localparam int CNT_MAX  = (CNT_MAX1 > FILL_NIB) ? CNT_MAX1 : FILL_NIB;
    localparam int CW       = $clog2(CNT_MAX + 1);

    state_t        state;
    owner_t        owner;
    owner_t        last_grant;
    logic [CW-1:0] cnt;
    logic [AW-1:0] addr_q;     // shifted left, MS nibble leaves first
    logic          wr_q;
    logic          size_q;
    logic [15:0]   wsh_q;      // shifted right, LS nibble leaves first
    logic [11:0]   rsh_q;      // previously sampled read nibbles, newest on top

    logic          elig_i;
    logic          grant_data;
    logic [CW-1:0] data_nibs;
    logic [CW-1:0] rd_nibs;
    logic [15:0]   rd_half;
    logic [15:0]   rd_byte;

    // A faulting pull is invisible to arbitration; on contention the side
    // that did not win last time gets the bus.
    assign elig_i     = i_pull & ~i_fault;
    assign grant_data = d_req & (~elig_i | (last_grant == ICACHE));

    assign data_nibs  = size_q ? CW'(4) : CW'(2);
    assign rd_nibs    = (owner == ICACHE) ? CW'(FILL_NIB) : data_nibs;

    // Final load value assembled from the nibble arriving this cycle.
    assign rd_half    = {m_din, rsh_q};
    assign rd_byte    = {8'h00, m_din, rsh_q[11:8]};

    // Transaction sequencer: arbitration, serialisers and all bus/icache/data outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            owner      <= ICACHE;
            last_grant <= ICACHE;
            cnt        <= '0;
            addr_q     <= '0;
            wr_q       <= 1'b0;
            size_q     <= 1'b0;
            wsh_q      <= '0;
            rsh_q      <= '0;
            m_csn      <= 1'b1;
            m_oe       <= 1'b0;
            m_dout     <= 4'h0;
            i_dread    <= 4'h0;
            i_wstrobe  <= 1'b0;
            d_ack      <= 1'b0;
            d_rdata    <= '0;
        end else begin
            i_wstrobe <= 1'b0;
            d_ack     <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (elig_i || d_req) begin
                        state  <= ST_CMD;
                        m_csn  <= 1'b0;
                        m_oe   <= 1'b1;
                        if (grant_data) begin
                            owner      <= DATA;
                            last_grant <= DATA;
                            addr_q     <= AW'(d_addr);
                            wr_q       <= d_write;
                            size_q     <= d_size;
                            wsh_q      <= d_wdata[15:0];
                            m_dout     <= d_write ? CMD_WRITE : CMD_READ;
                        end else begin
                            owner      <= ICACHE;
                            last_grant <= ICACHE;
                            addr_q     <= AW'({i_tag, {OFFW{1'b0}}});
                            wr_q       <= 1'b0;
                            size_q     <= 1'b0;
                            m_dout     <= CMD_READ;
                        end
                    end
                end

                ST_CMD: begin
                    state  <= ST_ADDR;
                    cnt    <= CW'(ANIB - 1);
                    m_dout <= addr_q[AW-1 -: 4];
                    addr_q <= addr_q << 4;
                end

                ST_ADDR: begin
                    if (cnt == '0) begin
                        if (wr_q) begin
                            // Writes go straight to data; the bus stays driven.
                            state  <= ST_WDATA;
                            cnt    <= data_nibs - CW'(1);
                            m_dout <= wsh_q[3:0];
                            wsh_q  <= {4'h0, wsh_q[15:4]};
                        end else begin
                            state <= ST_DUMMY;
                            cnt   <= CW'(DUMMY - 1);
                            m_oe  <= 1'b0;
                        end
                    end else begin
                        cnt    <= cnt - CW'(1);
                        m_dout <= addr_q[AW-1 -: 4];
                        addr_q <= addr_q << 4;
                    end
                end

                ST_DUMMY: begin
                    if (cnt == '0) begin
                        state <= ST_RDATA;
                        cnt   <= rd_nibs - CW'(1);
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end

                ST_RDATA: begin
                    rsh_q <= {m_din, rsh_q[11:4]};
                    // Fill nibbles are forwarded every cycle so the icache
                    // sees an unbroken strobe run.
                    if (owner == ICACHE) begin
                        i_dread   <= m_din;
                        i_wstrobe <= 1'b1;
                    end
                    if (cnt == '0) begin
                        state <= ST_DONE;
                        m_csn <= 1'b1;
                        if (owner == DATA) begin
                            d_ack   <= 1'b1;
                            d_rdata <= RV'(size_q ? rd_half : rd_byte);
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end

                ST_WDATA: begin
                    if (cnt == '0) begin
                        state <= ST_DONE;
                        m_csn <= 1'b1;
                        m_oe  <= 1'b0;
                        d_ack <= 1'b1;
                    end else begin
                        cnt    <= cnt - CW'(1);
                        m_dout <= wsh_q[3:0];
                        wsh_q  <= {4'h0, wsh_q[15:4]};
                    end
                end

                ST_DONE: begin
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                    m_csn <= 1'b1;
                    m_oe  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_nibble_arb.sv
// Purpose: randomized self-checking bench for mem_nibble_arb against a transaction-level model.
// Latency: expected bus schedule derived per transaction from nibble counts.
// Backpressure: requests stay pending in the model until their transaction completes.
module tb_mem_nibble_arb;

    localparam int PA    = 22;
    localparam int RV    = 16;
    localparam int LL    = 4;
    localparam int DUMMY = 2;
    localparam int TAGW  = PA - 2;
    localparam int ANIB  = 6;
    localparam int FILLN = LL * 2;
    localparam int RD0   = 1 + ANIB + DUMMY + 1;   // first RDATA cycle after grant

    logic            clk = 1'b0;
    logic            reset;
    logic            i_pull;
    logic [TAGW-1:0] i_tag;
    logic            i_fault;
    logic [3:0]      i_dread;
    logic            i_wstrobe;
    logic            d_req;
    logic            d_write;
    logic            d_size;
    logic [PA-1:0]   d_addr;
    logic [RV-1:0]   d_wdata;
    logic            d_ack;
    logic [RV-1:0]   d_rdata;
    logic            m_csn;
    logic            m_oe;
    logic [3:0]      m_dout;
    logic [3:0]      m_din;

    always #5 clk = ~clk;

    mem_nibble_arb #(.PA(PA), .RV(RV), .LINE_LENGTH(LL), .DUMMY(DUMMY)) dut (
        .clk(clk), .reset(reset),
        .i_pull(i_pull), .i_tag(i_tag), .i_fault(i_fault),
        .i_dread(i_dread), .i_wstrobe(i_wstrobe),
        .d_req(d_req), .d_write(d_write), .d_size(d_size), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata),
        .m_csn(m_csn), .m_oe(m_oe), .m_dout(m_dout), .m_din(m_din)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: pending requests and the arbitration history.
    bit              pend_i, pend_d, flt, dw, ds;
    logic [TAGW-1:0] tag_i;
    logic [PA-1:0]   da;
    logic [15:0]     dwd;
    bit              last_data = 1'b0;
    bit              at_done   = 1'b0;
    logic [3:0]      din_q [FILLN];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic rand_din();
        for (int j = 0; j < FILLN; j++) din_q[j] = 4'($urandom);
    endtask

    // Checks one granted transaction cycle by cycle, starting at the negedge of the grant cycle.
    task automatic do_txn(input bit is_fill, input bit wr, input bit sz,
                          input logic [23:0] a24, input logic [15:0] wd, input bit perturb);
        int          n, l, mid;
        bit          exp_oe, exp_stb;
        logic [31:0] er;
        n   = is_fill ? FILLN : (sz ? 4 : 2);
        l   = 1 + ANIB + (wr ? 0 : DUMMY) + n;
        mid = $urandom_range(2, l);
        er  = 32'd0;
        for (int j = 0; j < n; j++) er = er | (32'(din_q[j]) << (4 * j));
        for (int k = 1; k <= l + 1; k++) begin
            @(negedge clk);
            chk("csn", 32'(m_csn), 32'(k > l));
            exp_oe = (k <= 1 + ANIB) || (wr && k <= l);
            chk("oe", 32'(m_oe), 32'(exp_oe));
            if (k == 1)
                chk("cmd", 32'(m_dout), wr ? 32'd2 : 32'd1);
            else if (k <= 1 + ANIB)
                chk("addr_nib", 32'(m_dout), 32'(a24[4 * (ANIB + 1 - k) +: 4]));
            else if (wr && k <= l)
                chk("wdata_nib", 32'(m_dout), 32'(wd[4 * (k - 2 - ANIB) +: 4]));
            exp_stb = is_fill && (k >= RD0 + 1) && (k <= RD0 + n);
            chk("wstrobe", 32'(i_wstrobe), 32'(exp_stb));
            if (exp_stb) chk("dread", 32'(i_dread), 32'(din_q[k - RD0 - 1]));
            chk("ack", 32'(d_ack), 32'(!is_fill && k == l + 1));
            if (!is_fill && !wr && k == l + 1) chk("rdata", 32'(d_rdata), er);
            if (!wr && k >= RD0 && k < RD0 + n) m_din = din_q[k - RD0];
            else m_din = 4'($urandom);
            if (is_fill && perturb && k == mid) begin
                i_fault = 1'b1;
                i_pull  = 1'($urandom);
            end
        end
    endtask

    // Presents the pending requests, predicts the winner and checks the resulting transaction.
    task automatic step(input bit perturb);
        bit ei, ed, gd;
        i_pull  = pend_i;
        i_tag   = tag_i;
        i_fault = flt;
        d_req   = pend_d;
        d_write = dw;
        d_size  = ds;
        d_addr  = da;
        d_wdata = dwd;
        if (at_done) begin
            @(negedge clk);
            chk("idle_csn", 32'(m_csn), 32'd1);
        end
        ei = pend_i && !flt;
        ed = pend_d;
        if (!ei && !ed) begin
            repeat (3) begin
                @(negedge clk);
                chk("noreq_csn", 32'(m_csn), 32'd1);
                chk("noreq_stb", 32'(i_wstrobe), 32'd0);
            end
            at_done = 1'b0;
            return;
        end
        gd = ed && (!ei || !last_data);
        last_data = gd;
        if (gd) begin
            do_txn(1'b0, dw, ds, {2'b00, da}, dwd, 1'b0);
            pend_d = 1'b0;
        end else begin
            do_txn(1'b1, 1'b0, 1'b0, {2'b00, tag_i, 2'b00}, 16'h0, perturb);
            pend_i = 1'b0;
        end
        at_done = 1'b1;
    endtask

    task automatic new_data();
        pend_d = 1'b1;
        dw     = 1'($urandom);
        ds     = 1'($urandom);
        da     = PA'($urandom);
        dwd    = 16'($urandom);
    endtask

    initial begin
        reset = 1'b1;
        i_pull = 1'b0; i_tag = '0; i_fault = 1'b0;
        d_req = 1'b0; d_write = 1'b0; d_size = 1'b0; d_addr = '0; d_wdata = '0;
        m_din = 4'h0;
        pend_i = 1'b0; pend_d = 1'b0; flt = 1'b0; dw = 1'b0; ds = 1'b0;
        tag_i = '0; da = '0; dwd = '0;
        repeat (3) @(negedge clk);
        chk("rst_csn", 32'(m_csn), 32'd1);
        chk("rst_oe", 32'(m_oe), 32'd0);
        chk("rst_dout", 32'(m_dout), 32'd0);
        chk("rst_stb", 32'(i_wstrobe), 32'd0);
        chk("rst_dread", 32'(i_dread), 32'd0);
        chk("rst_ack", 32'(d_ack), 32'd0);
        chk("rst_rdata", 32'(d_rdata), 32'd0);
        reset = 1'b0;

        // Contention from reset: data first, then alternating.
        repeat (3) begin
            if (!pend_i) begin pend_i = 1'b1; tag_i = TAGW'($urandom); end
            if (!pend_d) new_data();
            flt = 1'b0;
            rand_din();
            step(1'b0);
        end
        pend_i = 1'b0;
        pend_d = 1'b0;

        // Directed fill, halfword load and byte store.
        pend_i = 1'b1; tag_i = 20'h0ABCD; flt = 1'b0;
        for (int j = 0; j < FILLN; j++) din_q[j] = 4'(j);
        step(1'b0);
        pend_d = 1'b1; dw = 1'b0; ds = 1'b1; da = 22'h012345; dwd = 16'h0;
        din_q[0] = 4'h5; din_q[1] = 4'hA; din_q[2] = 4'h3; din_q[3] = 4'hC;
        step(1'b0);
        pend_d = 1'b1; dw = 1'b1; ds = 1'b0; da = 22'h3FFFFF; dwd = 16'h00E7;
        step(1'b0);

        // Faulting pull is never granted; a fault raised mid-fill does not abort it.
        pend_i = 1'b1; tag_i = TAGW'($urandom); flt = 1'b1;
        step(1'b0);
        flt = 1'b0;
        rand_din();
        step(1'b1);

        // Reset during RDATA cycle 3 of a fill abandons it.
        pend_i = 1'b1; tag_i = TAGW'($urandom); flt = 1'b0; pend_d = 1'b0;
        rand_din();
        i_pull = 1'b1; i_tag = tag_i; i_fault = 1'b0; d_req = 1'b0;
        if (at_done) @(negedge clk);
        for (int k = 1; k <= RD0 + 3; k++) begin
            @(negedge clk);
            if (k >= RD0) m_din = din_q[k - RD0];
        end
        reset  = 1'b1;
        i_pull = 1'b0;
        @(negedge clk);
        chk("abort_csn", 32'(m_csn), 32'd1);
        chk("abort_stb", 32'(i_wstrobe), 32'd0);
        chk("abort_oe", 32'(m_oe), 32'd0);
        chk("abort_ack", 32'(d_ack), 32'd0);
        reset = 1'b0;
        pend_i = 1'b0; last_data = 1'b0; at_done = 1'b0;
        pend_i = 1'b1; tag_i = TAGW'($urandom);
        rand_din();
        step(1'b0);

        // Randomized mix of fills, loads, stores, faults and contention.
        repeat (80) begin
            if (!pend_i && $urandom_range(0, 2) != 0) begin
                pend_i = 1'b1;
                tag_i  = TAGW'($urandom);
            end
            if (!pend_d && $urandom_range(0, 2) != 0) new_data();
            flt = ($urandom_range(0, 4) == 0);
            rand_din();
            step($urandom_range(0, 3) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
